fifo_wr_arbiter: RTL
====================

# fifo_wr_arbiter

Round-robin write-port arbiter that lets NREQ producers share the single write port of the team's parameterized synchronous FIFO. Each producer raises a request and holds its data until acknowledged. The arbiter grants one producer at a time for a burst of up to BURST beats and drives the FIFO's write and data inputs. It observes the FIFO's full flag, so no beat is ever lost or duplicated.

## Interface
- WIDTH, 8: data width; must match the FIFO WIDTH.
- NREQ, 4: number of requesters (≥2).
- IDX_W, 2: owner index width; must satisfy 2^IDX_W ≥ NREQ.
- BURST, 4: maximum beats per grant (≥1).
- CNT_W, 3: beat counter width; must satisfy 2^CNT_W > BURST.

- clk  input  1  single clock; all state changes on the rising edge.
- rstn  input  1  asynchronous, active-low reset.
- req  input  NREQ  per-requester request; held high while that requester has data pending.
- din_bus  input  NREQ*WIDTH  requester i's data is slice [i*WIDTH +: WIDTH]; stable while req[i] is high and no ack.
- fifo_full  input  1  FIFO full flag.
- fifo_write  output  1  write strobe to the FIFO.
- fifo_din  output  WIDTH  write data to the FIFO.
- ack  output  NREQ  one-hot beat acknowledge; a beat transfers at the edge where ack[i]=1.
- busy  output  1  high in BUSY state.
- owner  output  IDX_W  index of the current grant holder (valid when busy).

## Operation
- State machine with two states, IDLE and BUSY. Registers: state, owner, last_owner, beat_cnt.
- Reset (async): state=IDLE, owner=0, beat_cnt=0, last_owner=NREQ-1, so requester 0 has highest priority first.
- Outputs are combinational from registers and inputs:
  - fifo_write = busy & req[owner] & ~fifo_full.
  - ack[owner] = fifo_write; all other ack bits 0.
  - fifo_din = slice owner of din_bus while busy; 0 in IDLE.
- IDLE:
  - If any req bit is set, pick the first set bit searching from last_owner+1 upward, modulo NREQ.
  - Load owner with that index, clear beat_cnt, go to BUSY.
  - If no req bit is set, stay in IDLE.
- BUSY, per edge:
  - If fifo_write, beat_cnt += 1.
  - Burst ends when either:
    - fifo_write and beat_cnt == BURST-1 (the last beat), or
    - req[owner] == 0 (requester withdrew; no beat this cycle).
  - On burst end: last_owner := owner, beat_cnt := 0, go to IDLE.
- fifo_full stall: no ack, beat_cnt frozen, no timeout, grant retained indefinitely.
- Simultaneous requests: strict round robin; after a burst the previous owner has lowest priority.
- Requests from non-owners never affect the current burst.
- Width rule: beat_cnt never exceeds BURST-1; owner arithmetic wraps modulo NREQ, including for non-power-of-2 NREQ.

## Timing
- Arbitration latency: 1 cycle. A req seen at edge N in IDLE gives busy=1 after edge N; the first ack can appear in cycle N+1.
- Sustained throughput: BURST beats per BURST+1 cycles. There is one mandatory IDLE bubble between bursts, even if the same requester continues.
- ack/fifo_write follow fifo_full and req combinationally in the same cycle; no registered path.
- A requester seeing ack[i]=1 may present new data, or drop req, in the next cycle.
- Reset asserted mid-burst: all outputs go to 0 immediately; any beat in progress is not transferred.

## Test plan
- Reset: hold rstn=0 with req=4'b1111, fifo_full=0 -> fifo_write=0, ack=0, busy=0, fifo_din=0. After release, the first grant goes to owner=0.
- Single requester: req=4'b0100, data 0xA5 held for 12 cycles -> busy one cycle after req; acks in 4 consecutive cycles with fifo_din=0xA5; 1 idle cycle; then a second 4-beat burst to owner=2.
- Full contention: req=4'b1111 continuously, distinct data per requester -> grants in order 0,1,2,3,0. Each burst is exactly 4 acks, with 5 cycles between grant starts.
- Full stall: fifo_full=1 for 3 cycles after beat 2 of a burst -> fifo_write=ack=0 for those 3 cycles, then beats 3 and 4. Exactly 4 writes total and no duplicated data.
- Early withdrawal: requester 1 drops req after 2 acks while req[3]=1 -> requester 1's burst ends after 2 writes, IDLE for 1 cycle, then owner=3.
- Reset mid-burst: rstn=0 for 1 cycle after beat 1 of requester 2 -> outputs 0 immediately. After release with req=4'b1111, the grant goes to requester 0, not 3.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-port arbiter. Several producers share one FIFO write port.
// A grant covers up to BURST beats. Beats stall while the FIFO is full. The
// previous owner drops to lowest priority after its burst.
module fifo_wr_arbiter #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned NREQ  = 4,
    parameter int unsigned IDX_W = 2,
    parameter int unsigned BURST = 4,
    parameter int unsigned CNT_W = 3
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] din_bus,
    input  logic                  fifo_full,
    output logic                  fifo_write,
    output logic [WIDTH-1:0]      fifo_din,
    output logic [NREQ-1:0]       ack,
    output logic                  busy,
    output logic [IDX_W-1:0]      owner
);

    // Elaboration-time sanity checks on the parameter set.
    if (NREQ < 2) begin : g_chk_nreq
        $error("fifo_wr_arbiter: NREQ must be at least 2");
    end
    if ((1 << IDX_W) < NREQ) begin : g_chk_idx_w
        $error("fifo_wr_arbiter: IDX_W too narrow for NREQ");
    end
    if (BURST < 1) begin : g_chk_burst
        $error("fifo_wr_arbiter: BURST must be at least 1");
    end
    if ((1 << CNT_W) <= BURST) begin : g_chk_cnt_w
        $error("fifo_wr_arbiter: CNT_W too narrow for BURST");
    end

    typedef enum logic [0:0] {
        StIdle,
        StBusy
    } state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] owner_q, owner_d;
    logic [IDX_W-1:0] last_owner_q, last_owner_d;
    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;

    logic             pick_valid;
    logic [IDX_W-1:0] pick_idx;
    int unsigned      cand;

    // Round-robin search: the first requester after last_owner, wrapping modulo NREQ.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        cand       = 0;
        for (int unsigned i = 1; i <= NREQ; i++) begin
            cand = (32'(last_owner_q) + i) % NREQ;
            if (!pick_valid && req[cand]) begin
                pick_valid = 1'b1;
                pick_idx   = IDX_W'(cand);
            end
        end
    end

    // Outputs are combinational, so a full FIFO or a dropped request masks the beat at once.
    always_comb begin
        busy       = (state_q == StBusy);
        owner      = owner_q;
        fifo_write = busy & req[owner_q] & ~fifo_full;
        ack        = '0;
        ack[owner_q] = fifo_write;
        fifo_din   = busy ? din_bus[32'(owner_q) * WIDTH +: WIDTH] : '0;
    end

    // Next-state logic. Grant in IDLE; count beats and detect burst end in BUSY.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        beat_cnt_d   = beat_cnt_q;
        unique case (state_q)
            StIdle: begin
                if (pick_valid) begin
                    owner_d    = pick_idx;
                    beat_cnt_d = '0;
                    state_d    = StBusy;
                end
            end
            StBusy: begin
                if (fifo_write) begin
                    if (beat_cnt_q == CNT_W'(BURST - 1)) begin
                        last_owner_d = owner_q;
                        beat_cnt_d   = '0;
                        state_d      = StIdle;
                    end else begin
                        beat_cnt_d = beat_cnt_q + CNT_W'(1);
                    end
                end else if (!req[owner_q]) begin
                    // Requester withdrew. A full-FIFO stall keeps the grant instead.
                    last_owner_d = owner_q;
                    beat_cnt_d   = '0;
                    state_d      = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers. Reset makes requester 0 the highest priority.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= StIdle;
            owner_q      <= '0;
            last_owner_q <= IDX_W'(NREQ - 1);
            beat_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            beat_cnt_q   <= beat_cnt_d;
        end
    end

endmodule
